// File: rtl/pkt_seq_generator_pkg.sv
// ---------------------------------------------------------------------------
// pkt_seq_generator_pkg : shared FSM encodings, defaults and counter opcodes
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pkt_seq_generator_pkg;

  localparam int DEF_BUS_SIZE  = 16;
  localparam int DEF_WORD_SIZE = 4;
  localparam int CNT_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESYNC = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CNT_HOLD  = 2'd0,
    CNT_CLR   = 2'd1,
    CNT_LOAD1 = 2'd2,
    CNT_INC   = 2'd3
  } cnt_op_e;

  // All-ones header code for a given word width.
  function automatic logic [31:0] def_f_code(input int word_size);
    return (32'd1 << word_size) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_seq_generator_if.sv
// ---------------------------------------------------------------------------
// pkt_seq_generator_if : control inputs and generated-word bus of the generator
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pkt_seq_generator_if #(
  parameter int BUS_SIZE = 16
);
  logic                enable;
  logic                inj_hdr_err;
  logic                inj_seq_err;
  logic [BUS_SIZE-1:0] data_bus;
  logic                valid;
  logic                inj_ack;
  logic [15:0]         pkt_count;

  modport master (
    input  enable, inj_hdr_err, inj_seq_err,
    output data_bus, valid, inj_ack, pkt_count
  );

  modport slave (
    output enable, inj_hdr_err, inj_seq_err,
    input  data_bus, valid, inj_ack, pkt_count
  );
endinterface

`default_nettype wire

// File: rtl/pkt_seq_generator_seq_word_counter.sv
// ---------------------------------------------------------------------------
// seq_word_counter : WORD_SIZE-bit sequence counter (clear, load-1, wrap-inc)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_word_counter
  import pkt_seq_generator_pkg::*;
#(
  parameter int WORD_SIZE = 4
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  cnt_op_e                   op_i,
  output logic      [WORD_SIZE-1:0] seq_o
);

  localparam logic [WORD_SIZE-1:0] C_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  logic [WORD_SIZE-1:0] seq_q;
  logic [WORD_SIZE-1:0] seq_d;

  always_comb begin
    seq_d = seq_q;
    case (op_i)
      CNT_CLR:   seq_d = '0;
      CNT_LOAD1: seq_d = C_ONE;
      CNT_INC:   seq_d = seq_q + C_ONE;
      default:   seq_d = seq_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) seq_q <= C_ONE;
    else        seq_q <= seq_d;
  end

  assign seq_o = seq_q;

endmodule

`default_nettype wire

// File: rtl/pkt_seq_generator.sv
// ---------------------------------------------------------------------------
// pkt_seq_generator : streams {header, payload, seq} words with error injection
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pkt_seq_generator
  import pkt_seq_generator_pkg::*;
#(
  parameter int                   BUS_SIZE  = DEF_BUS_SIZE,
  parameter int                   WORD_SIZE = DEF_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] F_CODE    = {WORD_SIZE{1'b1}}
) (
  input  wire logic               clk,
  input  wire logic               reset,
  pkt_seq_generator_if.master     bus
);

  localparam int WORD_NUM = BUS_SIZE / WORD_SIZE;
  localparam int LOW_W    = BUS_SIZE - WORD_SIZE;
  localparam int PAY_W    = (WORD_NUM - 2) * WORD_SIZE;

  state_e               state_q, state_d;
  cnt_op_e              cnt_op;
  logic [WORD_SIZE-1:0] seq;
  logic [BUS_SIZE-1:0]  data_bus_q, data_bus_d;
  logic                 valid_q, valid_d;
  logic                 inj_ack_q, inj_ack_d;
  logic [CNT_W-1:0]     pkt_count_q, pkt_count_d;

  logic                 w_emit;
  logic [WORD_SIZE-1:0] w_hdr;
  logic [WORD_SIZE-1:0] w_seq_field;
  logic [LOW_W-1:0]     w_payload_pos;
  logic [BUS_SIZE-1:0]  w_word;

  seq_word_counter #(
    .WORD_SIZE (WORD_SIZE)
  ) u_seq_cnt (
    .clk   (clk),
    .reset (reset),
    .op_i  (cnt_op),
    .seq_o (seq)
  );

  // Payload sits between header and seq, taken from the pre-increment count.
  if (PAY_W == 0) begin : g_no_payload
    assign w_payload_pos = '0;
  end else if (PAY_W <= CNT_W) begin : g_payload
    assign w_payload_pos = {pkt_count_q[PAY_W-1:0], {WORD_SIZE{1'b0}}};
  end else begin : g_payload_wide
    assign w_payload_pos = {{(PAY_W-CNT_W){1'b0}}, pkt_count_q, {WORD_SIZE{1'b0}}};
  end

  assign w_word = {w_hdr, w_payload_pos | LOW_W'(w_seq_field)};

  always_comb begin
    state_d     = state_q;
    cnt_op      = CNT_HOLD;
    w_emit      = 1'b0;
    w_hdr       = F_CODE;
    w_seq_field = seq;
    inj_ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          w_emit  = 1'b1;
          cnt_op  = CNT_INC;
          state_d = ST_RUN;
        end else begin
          cnt_op  = CNT_LOAD1;
        end
      end

      ST_RUN: begin
        if (!bus.enable) begin
          cnt_op  = CNT_LOAD1;
          state_d = ST_IDLE;
        end else begin
          w_emit = 1'b1;
          // Header error takes precedence; clearing seq lets RESYNC emit 0.
          if (bus.inj_hdr_err) begin
            w_hdr     = ~F_CODE;
            inj_ack_d = 1'b1;
            cnt_op    = CNT_CLR;
            state_d   = ST_RESYNC;
          end else if (bus.inj_seq_err) begin
            w_seq_field = seq + {{(WORD_SIZE-1){1'b0}}, 1'b1};
            inj_ack_d   = 1'b1;
            cnt_op      = CNT_CLR;
            state_d     = ST_RESYNC;
          end else begin
            cnt_op = CNT_INC;
          end
        end
      end

      ST_RESYNC: begin
        cnt_op = CNT_LOAD1;
        if (bus.enable) begin
          w_emit  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        cnt_op  = CNT_LOAD1;
        state_d = ST_IDLE;
      end
    endcase

    data_bus_d  = w_emit ? w_word : '0;
    valid_d     = w_emit;
    pkt_count_d = (w_emit && (pkt_count_q != {CNT_W{1'b1}})) ?
                  pkt_count_q + {{(CNT_W-1){1'b0}}, 1'b1} : pkt_count_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      data_bus_q  <= '0;
      valid_q     <= 1'b0;
      inj_ack_q   <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      data_bus_q  <= data_bus_d;
      valid_q     <= valid_d;
      inj_ack_q   <= inj_ack_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign bus.data_bus  = data_bus_q;
  assign bus.valid     = valid_q;
  assign bus.inj_ack   = inj_ack_q;
  assign bus.pkt_count = pkt_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pkt_seq_generator.sv
// ---------------------------------------------------------------------------
// tb_pkt_seq_generator : directed self-checking bench for pkt_seq_generator
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pkt_seq_generator;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pkt_seq_generator_if #(.BUS_SIZE(16)) bus_if ();

  pkt_seq_generator #(
    .BUS_SIZE  (16),
    .WORD_SIZE (4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic word(input string tag, input logic [15:0] exp_data, input logic exp_ack);
    step();
    chk({tag, "_data"}, 32'(bus_if.data_bus), 32'(exp_data));
    chk({tag, "_valid"}, 32'(bus_if.valid), 32'd1);
    chk({tag, "_ack"}, 32'(bus_if.inj_ack), 32'(exp_ack));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_data"}, 32'(bus_if.data_bus), 32'h0);
    chk({tag, "_valid"}, 32'(bus_if.valid), 32'd0);
    chk({tag, "_ack"}, 32'(bus_if.inj_ack), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus_if.enable      = 1'b0;
    bus_if.inj_hdr_err = 1'b0;
    bus_if.inj_seq_err = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset              = 1'b0;
    bus_if.enable      = 1'b0;
    bus_if.inj_hdr_err = 1'b0;
    bus_if.inj_seq_err = 1'b0;

    // Reset state
    repeat (3) step();
    idle_chk("rst");
    chk("rst_cnt", 32'(bus_if.pkt_count), 32'd0);

    // Clean stream and seq wrap
    reset = 1'b1;
    bus_if.enable = 1'b1;
    word("w1", 16'hF001, 1'b0);
    word("w2", 16'hF012, 1'b0);
    word("w3", 16'hF023, 1'b0);
    repeat (11) step();
    word("w15", 16'hF0EF, 1'b0);
    word("w16", 16'hF0F0, 1'b0);
    chk("cnt16", 32'(bus_if.pkt_count), 32'd16);
    word("w17", 16'hF101, 1'b0);

    // Enable drop has priority over injection; IDLE ignores injection
    bus_if.enable      = 1'b0;
    bus_if.inj_hdr_err = 1'b1;
    step();
    idle_chk("drop");
    chk("drop_cnt", 32'(bus_if.pkt_count), 32'd17);
    step();
    idle_chk("idle_inj");
    bus_if.enable = 1'b1;
    word("reen", 16'hF111, 1'b0);
    bus_if.inj_hdr_err = 1'b0;

    // Reset mid-stream
    reset = 1'b0;
    step();
    idle_chk("midrst");
    chk("midrst_cnt", 32'(bus_if.pkt_count), 32'd0);

    // Header error; injection held through RESYNC is ignored
    reset = 1'b1;
    word("h1", 16'hF001, 1'b0);
    word("h2", 16'hF012, 1'b0);
    bus_if.inj_hdr_err = 1'b1;
    word("hdr", 16'h0023, 1'b1);
    word("hres", 16'hF030, 1'b0);
    bus_if.inj_hdr_err = 1'b0;
    word("hrun", 16'hF041, 1'b0);

    // Sequence error
    do_reset();
    bus_if.enable = 1'b1;
    word("s1", 16'hF001, 1'b0);
    word("s2", 16'hF012, 1'b0);
    bus_if.inj_seq_err = 1'b1;
    word("seq", 16'hF024, 1'b1);
    bus_if.inj_seq_err = 1'b0;
    word("sres", 16'hF030, 1'b0);
    word("srun", 16'hF041, 1'b0);

    // Both injects together, then enable drop out of RESYNC
    do_reset();
    bus_if.enable = 1'b1;
    word("b1", 16'hF001, 1'b0);
    word("b2", 16'hF012, 1'b0);
    bus_if.inj_hdr_err = 1'b1;
    bus_if.inj_seq_err = 1'b1;
    word("both", 16'h0023, 1'b1);
    bus_if.inj_hdr_err = 1'b0;
    bus_if.inj_seq_err = 1'b0;
    bus_if.enable      = 1'b0;
    step();
    idle_chk("resdrop");
    bus_if.enable = 1'b1;
    word("resreen", 16'hF031, 1'b0);

    // pkt_count saturation
    do_reset();
    bus_if.enable = 1'b1;
    repeat (65534) step();
    chk("cnt_fffe", 32'(bus_if.pkt_count), 32'h0000FFFE);
    step();
    chk("cnt_ffff", 32'(bus_if.pkt_count), 32'h0000FFFF);
    word("sat1", 16'hFFF0, 1'b0);
    chk("sat1_cnt", 32'(bus_if.pkt_count), 32'h0000FFFF);
    word("sat2", 16'hFFF1, 1'b0);
    chk("sat2_cnt", 32'(bus_if.pkt_count), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
